// File: rtl/small_cpu_pkg.sv
// Shared opcode and FSM state encodings for the multi-cycle accumulator core.
package small_cpu_pkg;

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_XOR   = 4'd1;
    localparam logic [3:0] OP_OR    = 4'd2;
    localparam logic [3:0] OP_AND   = 4'd3;
    localparam logic [3:0] OP_SEQ   = 4'd4;
    localparam logic [3:0] OP_SLT   = 4'd5;
    localparam logic [3:0] OP_SL    = 4'd6;
    localparam logic [3:0] OP_SR    = 4'd7;
    localparam logic [3:0] OP_IMM   = 4'd8;
    localparam logic [3:0] OP_JAL   = 4'd9;
    localparam logic [3:0] OP_STORE = 4'd10;
    localparam logic [3:0] OP_MOVE  = 4'd11;
    localparam logic [3:0] OP_BNZ   = 4'd12;
    localparam logic [3:0] OP_LOAD  = 4'd13;
    localparam logic [3:0] OP_NOP   = 4'd14;
    localparam logic [3:0] OP_HALT  = 4'd15;

    localparam logic [1:0] ST_FETCH = 2'd0;
    localparam logic [1:0] ST_EXEC  = 2'd1;
    localparam logic [1:0] ST_MEM   = 2'd2;
    localparam logic [1:0] ST_HALT  = 2'd3;

endpackage

// File: rtl/acc_alu.sv
// Combinational ALU for accumulator ops 0-7 (R0 op memory operand).
module acc_alu
    import small_cpu_pkg::*;
#(
    parameter int N = 16
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [3:0]   op,
    output logic [N-1:0] y
);

    localparam int SW = $clog2(N);

    logic [SW-1:0] w_sh;

    assign w_sh = b[SW-1:0];

    always_comb begin
        y = '0;
        case (op)
            OP_ADD: y = a + b;
            OP_XOR: y = a ^ b;
            OP_OR:  y = a | b;
            OP_AND: y = a & b;
            OP_SEQ: y = {{(N-1){1'b0}}, (a == b)};
            OP_SLT: y = {{(N-1){1'b0}}, (a < b)};
            OP_SL:  y = a << w_sh;
            OP_SR:  y = a >> w_sh;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/acc_cpu_mc.sv
// Multi-cycle accumulator CPU: FETCH/EXEC/MEM/HALT with ready handshakes
// on separate instruction and data ports.
module acc_cpu_mc
    import small_cpu_pkg::*;
#(
    parameter int          N        = 16,
    parameter int          NREGS    = 4,
    parameter logic [N-1:0] RESET_PC = '0
) (
    input  logic         clk,
    input  logic         rst,
    output logic         imem_req,
    output logic [N-1:0] imem_addr,
    input  logic [N-1:0] imem_rdata,
    input  logic         imem_ready,
    output logic         dmem_req,
    output logic         dmem_we,
    output logic [N-1:0] dmem_addr,
    output logic [N-1:0] dmem_wdata,
    input  logic [N-1:0] dmem_rdata,
    input  logic         dmem_ready,
    output logic         halted,
    output logic [N-1:0] pc
);

    localparam int RW = $clog2(NREGS);

    logic [1:0]   r_state;
    logic [N-1:0] r_pc;
    logic [N-1:0] r_ir;
    logic [N-1:0] r_regs [NREGS];

    logic [3:0]    w_op;
    logic [N-5:0]  w_imm;
    logic [N-1:0]  w_imm_z;
    logic [N-1:0]  w_ea;
    logic [N-1:0]  w_pc_inc;
    logic [N-1:0]  w_alu;
    logic [RW-1:0] w_dst;
    logic [RW-1:0] w_src;

    assign w_op     = r_ir[N-1:N-4];
    assign w_imm    = r_ir[N-5:0];
    assign w_imm_z  = {4'b0000, w_imm};
    assign w_ea     = w_imm_z + r_regs[1];
    assign w_pc_inc = r_pc + N'(1);
    assign w_dst    = w_imm[2*RW-1:RW];
    assign w_src    = w_imm[RW-1:0];

    // Requests are dropped in the same cycle reset is raised.
    assign imem_req   = !rst && (r_state == ST_FETCH);
    assign dmem_req   = !rst && (r_state == ST_MEM);
    assign dmem_we    = dmem_req && (w_op == OP_STORE);
    assign halted     = !rst && (r_state == ST_HALT);
    assign imem_addr  = r_pc;
    assign dmem_addr  = w_ea;
    assign dmem_wdata = r_regs[0];
    assign pc         = r_pc;

    acc_alu #(.N(N)) u_alu (
        .a  (r_regs[0]),
        .b  (dmem_rdata),
        .op (w_op),
        .y  (w_alu)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_FETCH;
            r_pc    <= RESET_PC;
            r_ir    <= '0;
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            case (r_state)
                ST_FETCH: begin
                    if (imem_ready) begin
                        r_ir    <= imem_rdata;
                        r_state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    r_state <= ST_FETCH;
                    case (w_op)
                        OP_IMM: begin
                            r_regs[0] <= w_imm_z;
                            r_pc      <= w_pc_inc;
                        end
                        OP_JAL: begin
                            r_regs[0] <= w_pc_inc;
                            r_pc      <= w_ea;
                        end
                        OP_BNZ: begin
                            r_pc <= (r_regs[0] != '0) ? w_ea : w_pc_inc;
                        end
                        OP_MOVE: begin
                            r_regs[w_dst] <= r_regs[w_src];
                            r_pc          <= w_pc_inc;
                        end
                        OP_NOP:  r_pc    <= w_pc_inc;
                        OP_HALT: r_state <= ST_HALT;
                        default: r_state <= ST_MEM;
                    endcase
                end
                ST_MEM: begin
                    if (dmem_ready) begin
                        if (w_op == OP_LOAD) begin
                            r_regs[0] <= dmem_rdata;
                        end else if (w_op != OP_STORE) begin
                            r_regs[0] <= w_alu;
                        end
                        r_pc    <= w_pc_inc;
                        r_state <= ST_FETCH;
                    end
                end
                default: r_state <= ST_HALT;
            endcase
        end
    end

endmodule
